// File: rtl/process_scheduler_pkg.sv
// Shared state encoding, OS base address and id-width helper for the process scheduler.
package sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCHED,
    LOAD,
    RUN,
    SAVE
  } sched_state_t;

  localparam int OS_BASE       = 0;
  localparam int NPROC_DEFAULT = 4;

  // A single-slot table still needs a one-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_width(NPROC_DEFAULT);

endpackage

// File: rtl/process_scheduler_if.sv
// Control-unit / PC-register side of the scheduler: retire and end events in, load and preempt controls out.
interface process_scheduler_if
  import sched_pkg::*;
#(
  parameter int NPROC  = 4,
  parameter int ADDR_W = 32
) ();

  localparam int IDW = id_width(NPROC);

  logic              stop;
  logic              inst_exec;
  logic              prog_end;
  logic [ADDR_W-1:0] pc_atual;
  logic              cria_valid;
  logic [IDW-1:0]    cria_id;
  logic [ADDR_W-1:0] cria_pc;
  logic              cria_ok;
  logic              preempt;
  logic              lpc;
  logic [ADDR_W-1:0] pc_carga;
  logic [IDW-1:0]    prog_atual;
  logic              so_ativo;
  logic [NPROC-1:0]  prontos;

  modport master (
    output stop, inst_exec, prog_end, pc_atual, cria_valid, cria_id, cria_pc,
    input  cria_ok, preempt, lpc, pc_carga, prog_atual, so_ativo, prontos
  );

  modport slave (
    input  stop, inst_exec, prog_end, pc_atual, cria_valid, cria_id, cria_pc,
    output cria_ok, preempt, lpc, pc_carga, prog_atual, so_ativo, prontos
  );

endinterface

// File: rtl/process_scheduler_rr_picker.sv
// Combinational round-robin picker: first set bit of mask at or after start, wrapping past NPROC-1.
module rr_picker
  import sched_pkg::*;
#(
  parameter int NPROC = 4,
  parameter int IDW   = id_width(NPROC)
) (
  input  logic [NPROC-1:0] mask,
  input  logic [IDW-1:0]   start,
  output logic             found,
  output logic [IDW-1:0]   idx
);

  logic [IDW-1:0] j;

  // Walk from the farthest candidate back to start so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = NPROC - 1; k >= 0; k--) begin
      j = IDW'((int'(start) + k) % NPROC);
      if (mask[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin time-slice scheduler: owns the program table, counts retired instructions,
// and drives registered load/preempt pulses toward the PC register.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int NPROC       = 4,
  parameter int QUANTUM     = 5,
  parameter int OFFSET_STEP = 1000,
  parameter int ADDR_W      = 32
) (
  input logic                clock,
  input logic                reset,
  process_scheduler_if.slave sif
);

  localparam int IDW = id_width(NPROC);
  localparam int CW  = $clog2(QUANTUM + 1);

  sched_state_t      state;
  logic [NPROC-1:0]  valid;
  logic [ADDR_W-1:0] saved [NPROC];
  logic [CW-1:0]     count;
  logic [IDW-1:0]    prog;
  logic              cria_ok_r;
  logic              preempt_r;
  logic              lpc_r;
  logic              so_ativo_r;
  logic [ADDR_W-1:0] pc_carga_r;

  logic [IDW-1:0]    rr_start;
  logic              pick_found;
  logic [IDW-1:0]    pick_idx;
  logic [ADDR_W-1:0] cur_base;
  logic              cria_hit;

  assign rr_start = (int'(prog) == NPROC - 1) ? '0 : prog + 1'b1;
  assign cur_base = ADDR_W'((int'(prog) + 1) * OFFSET_STEP);
  assign cria_hit = sif.cria_valid && (int'(sif.cria_id) < NPROC) && !valid[sif.cria_id];

  rr_picker #(.NPROC(NPROC), .IDW(IDW)) u_picker (
    .mask  (valid),
    .start (rr_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      valid      <= '0;
      for (int i = 0; i < NPROC; i++) saved[i] <= '0;
      count      <= '0;
      prog       <= '0;
      cria_ok_r  <= 1'b0;
      preempt_r  <= 1'b0;
      lpc_r      <= 1'b0;
      so_ativo_r <= 1'b1;
      pc_carga_r <= ADDR_W'(OS_BASE);
    end else begin
      cria_ok_r <= 1'b0;
      preempt_r <= 1'b0;
      lpc_r     <= 1'b0;
      // While frozen only the pulses fall; LOAD/SAVE complete on the first free cycle.
      if (!sif.stop) begin
        if (cria_hit) begin
          valid[sif.cria_id] <= 1'b1;
          saved[sif.cria_id] <= sif.cria_pc;
          cria_ok_r          <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (|valid) state <= SCHED;
          end
          SCHED: begin
            if (pick_found) begin
              prog       <= pick_idx;
              so_ativo_r <= 1'b0;
              state      <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
          LOAD: begin
            lpc_r      <= 1'b1;
            pc_carga_r <= saved[prog] + cur_base;
            count      <= '0;
            state      <= RUN;
          end
          RUN: begin
            // A halting program is released without saving, even on its last quantum tick.
            if (sif.prog_end) begin
              valid[prog] <= 1'b0;
              preempt_r   <= 1'b1;
              so_ativo_r  <= 1'b1;
              state       <= SCHED;
            end else if (sif.inst_exec) begin
              count <= count + 1'b1;
              if (count == CW'(QUANTUM - 1)) begin
                preempt_r  <= 1'b1;
                so_ativo_r <= 1'b1;
                state      <= SAVE;
              end
            end
          end
          SAVE: begin
            saved[prog] <= sif.pc_atual - cur_base;
            state       <= SCHED;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign sif.cria_ok    = cria_ok_r;
  assign sif.preempt    = preempt_r;
  assign sif.lpc        = lpc_r;
  assign sif.pc_carga   = pc_carga_r;
  assign sif.prog_atual = prog;
  assign sif.so_ativo   = so_ativo_r;
  assign sif.prontos    = valid;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: directed scenarios plus a randomized run against a slot-table model.
`timescale 1ns/1ps
module tb_process_scheduler;
  import sched_pkg::*;

  localparam int NPROC       = 4;
  localparam int QUANTUM     = 5;
  localparam int OFFSET_STEP = 1000;
  localparam int ADDR_W      = 32;
  localparam int IDW         = id_width(NPROC);

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  process_scheduler_if #(.NPROC(NPROC), .ADDR_W(ADDR_W)) sif ();

  process_scheduler #(
    .NPROC(NPROC), .QUANTUM(QUANTUM), .OFFSET_STEP(OFFSET_STEP), .ADDR_W(ADDR_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sif   (sif)
  );

  always #5 clock = ~clock;

  // Reference model: which slots hold a program, their relative PCs, and who ran last.
  bit                m_valid [NPROC];
  logic [ADDR_W-1:0] m_saved [NPROC];
  int                m_cur;

  function automatic logic [ADDR_W-1:0] base_of(input int id);
    return ADDR_W'((id + 1) * OFFSET_STEP);
  endfunction

  function automatic int model_pick();
    for (int k = 1; k <= NPROC; k++)
      if (m_valid[(m_cur + k) % NPROC]) return (m_cur + k) % NPROC;
    return -1;
  endfunction

  function automatic logic [NPROC-1:0] model_mask();
    logic [NPROC-1:0] m;
    m = '0;
    for (int i = 0; i < NPROC; i++) m[i] = m_valid[i];
    return m;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    sif.stop       = 1'b0;
    sif.inst_exec  = 1'b0;
    sif.prog_end   = 1'b0;
    sif.cria_valid = 1'b0;
    sif.cria_id    = '0;
    sif.cria_pc    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    sif.pc_atual = '0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < NPROC; i++) begin
      m_valid[i] = 1'b0;
      m_saved[i] = '0;
    end
    m_cur = 0;
  endtask

  task automatic create(input int id, input logic [ADDR_W-1:0] pc, output logic ok);
    sif.cria_valid = 1'b1;
    sif.cria_id    = IDW'(id);
    sif.cria_pc    = pc;
    tick();
    ok = sif.cria_ok;
    sif.cria_valid = 1'b0;
  endtask

  task automatic wait_lpc(input int budget, output bit seen, output int waited);
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      tick();
      waited++;
      if (sif.lpc === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic run_quantum();
    for (int i = 0; i < QUANTUM; i++) begin
      sif.inst_exec = 1'b1;
      tick();
    end
    sif.inst_exec = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sif.stop = 1'b1; sif.inst_exec = 1'b1; sif.prog_end = 1'b1;
    sif.cria_valid = 1'b1; sif.cria_id = '0; sif.cria_pc = 32'd77; sif.pc_atual = 32'd5;
    tick();
    tick();
    checks++; if (sif.prontos !== 4'b0000) begin failures++; $display("FAIL reset_prontos got=%b want=0000", sif.prontos); end
    checks++; if (sif.so_ativo !== 1'b1) begin failures++; $display("FAIL reset_so_ativo got=%b want=1", sif.so_ativo); end
    checks++; if ({sif.lpc, sif.preempt, sif.cria_ok} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b want=000", {sif.lpc, sif.preempt, sif.cria_ok}); end
    checks++; if (sif.pc_carga !== 32'd0) begin failures++; $display("FAIL reset_pc_carga got=%0d want=0", sif.pc_carga); end
    checks++; if (sif.prog_atual !== 2'd0) begin failures++; $display("FAIL reset_prog_atual got=%0d want=0", sif.prog_atual); end
    do_reset();
  endtask

  task automatic test_single();
    logic ok; bit seen; int waited;
    do_reset();
    create(0, 32'd0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_cria_ok got=%b want=1", ok); end
    wait_lpc(10, seen, waited);
    checks++; if (!seen || waited != 3) begin failures++; $display("FAIL single_first_lpc seen=%0d after=%0d want seen after 3", seen, waited); end
    checks++; if (sif.pc_carga !== 32'd1000 || sif.so_ativo !== 1'b0) begin failures++; $display("FAIL single_load got pc=%0d so=%b want pc=1000 so=0", sif.pc_carga, sif.so_ativo); end
    tick();
    checks++; if (sif.lpc !== 1'b0) begin failures++; $display("FAIL single_lpc_width got=%b want=0", sif.lpc); end
    for (int i = 1; i <= QUANTUM; i++) begin
      sif.inst_exec = 1'b1;
      tick();
      checks++; if (sif.preempt !== (i == QUANTUM)) begin failures++; $display("FAIL single_preempt inst=%0d got=%b want=%b", i, sif.preempt, (i == QUANTUM)); end
    end
    sif.inst_exec = 1'b0;
    checks++; if (sif.so_ativo !== 1'b1) begin failures++; $display("FAIL single_so_in_save got=%b want=1", sif.so_ativo); end
    sif.pc_atual = 32'd1005;
    wait_lpc(10, seen, waited);
    checks++; if (!seen || waited != 3 || sif.pc_carga !== 32'd1005) begin failures++; $display("FAIL single_reload seen=%0d after=%0d pc=%0d want after 3 pc=1005", seen, waited, sif.pc_carga); end
  endtask

  task automatic test_round_robin();
    logic ok; bit seen; int waited;
    int exp_order [4] = '{0, 2, 0, 2};
    int exp_pc    [4] = '{1000, 3000, 1001, 3002};
    do_reset();
    create(0, 32'd0, ok);
    wait_lpc(10, seen, waited);
    checks++; if (!seen || sif.prog_atual !== 2'd0 || sif.pc_carga !== 32'd1000) begin failures++; $display("FAIL rr_round0 seen=%0d id=%0d pc=%0d want id=0 pc=1000", seen, sif.prog_atual, sif.pc_carga); end
    create(2, 32'd0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rr_create2 got=%b want=1", ok); end
    for (int n = 1; n < 4; n++) begin
      run_quantum();
      sif.pc_atual = ADDR_W'((exp_order[n-1] + 1) * OFFSET_STEP + n);
      wait_lpc(10, seen, waited);
      checks++; if (!seen || sif.prog_atual !== IDW'(exp_order[n]) || sif.pc_carga !== ADDR_W'(exp_pc[n])) begin
        failures++; $display("FAIL rr_round%0d seen=%0d id=%0d pc=%0d want id=%0d pc=%0d", n, seen, sif.prog_atual, sif.pc_carga, exp_order[n], exp_pc[n]);
      end
    end
  endtask

  task automatic test_end_priority();
    logic ok; bit seen; int waited;
    do_reset();
    create(0, 32'd0, ok);
    wait_lpc(10, seen, waited);
    create(1, 32'd0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL endp_create1 got=%b want=1", ok); end
    for (int i = 0; i < QUANTUM - 1; i++) begin
      sif.inst_exec = 1'b1;
      tick();
    end
    sif.prog_end = 1'b1;
    sif.pc_atual = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    checks++; if (sif.preempt !== 1'b1 || sif.prontos !== 4'b0010) begin failures++; $display("FAIL endp_release preempt=%b prontos=%b want 1 0010", sif.preempt, sif.prontos); end
    wait_lpc(10, seen, waited);
    checks++; if (!seen || waited != 2) begin failures++; $display("FAIL endp_no_save seen=%0d after=%0d want after 2", seen, waited); end
    checks++; if (sif.prog_atual !== 2'd1 || sif.pc_carga !== 32'd2000) begin failures++; $display("FAIL endp_next id=%0d pc=%0d want id=1 pc=2000", sif.prog_atual, sif.pc_carga); end
  endtask

  task automatic test_last_end();
    logic ok; bit seen; int waited; bit any_lpc;
    sif.prog_end = 1'b1;
    tick();
    sif.prog_end = 1'b0;
    checks++; if (sif.preempt !== 1'b1 || sif.prontos !== 4'b0000) begin failures++; $display("FAIL last_end preempt=%b prontos=%b want 1 0000", sif.preempt, sif.prontos); end
    any_lpc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (sif.lpc === 1'b1) any_lpc = 1'b1;
    end
    checks++; if (any_lpc || sif.so_ativo !== 1'b1) begin failures++; $display("FAIL last_idle lpc_seen=%0d so=%b want 0 1", any_lpc, sif.so_ativo); end
    create(3, 32'd7, ok);
    wait_lpc(10, seen, waited);
    checks++; if (!ok || !seen || sif.prog_atual !== 2'd3 || sif.pc_carga !== 32'd4007) begin failures++; $display("FAIL last_recreate ok=%b seen=%0d id=%0d pc=%0d want id=3 pc=4007", ok, seen, sif.prog_atual, sif.pc_carga); end
  endtask

  task automatic test_stop();
    logic ok; bit seen; int waited;
    do_reset();
    create(0, 32'd0, ok);
    wait_lpc(10, seen, waited);
    sif.inst_exec = 1'b1;
    tick();
    tick();
    sif.stop = 1'b1; sif.cria_valid = 1'b1; sif.cria_id = 2'd1; sif.cria_pc = 32'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (sif.preempt !== 1'b0 || sif.cria_ok !== 1'b0) begin failures++; $display("FAIL stop_frozen cyc=%0d preempt=%b cria_ok=%b want 0 0", i, sif.preempt, sif.cria_ok); end
    end
    sif.stop = 1'b0; sif.cria_id = 2'd0;
    tick();
    checks++; if (sif.cria_ok !== 1'b0 || sif.preempt !== 1'b0) begin failures++; $display("FAIL stop_dup_create cria_ok=%b preempt=%b want 0 0", sif.cria_ok, sif.preempt); end
    sif.cria_valid = 1'b0;
    tick();
    tick();
    checks++; if (sif.preempt !== 1'b1 || sif.prontos !== 4'b0001) begin failures++; $display("FAIL stop_count_held preempt=%b prontos=%b want 1 0001", sif.preempt, sif.prontos); end
    sif.inst_exec = 1'b0; sif.stop = 1'b1; sif.pc_atual = 32'd1234;
    tick();
    checks++; if (sif.preempt !== 1'b0) begin failures++; $display("FAIL stop_pulse_drop got=%b want=0", sif.preempt); end
    tick();
    checks++; if (sif.lpc !== 1'b0 || sif.so_ativo !== 1'b1) begin failures++; $display("FAIL stop_save_held lpc=%b so=%b want 0 1", sif.lpc, sif.so_ativo); end
    sif.stop = 1'b0; sif.pc_atual = 32'd1042;
    wait_lpc(10, seen, waited);
    checks++; if (!seen || waited != 3 || sif.pc_carga !== 32'd1042) begin failures++; $display("FAIL stop_save_done seen=%0d after=%0d pc=%0d want after 3 pc=1042", seen, waited, sif.pc_carga); end
  endtask

  task automatic test_reset_mid();
    logic ok; bit seen; int waited;
    do_reset();
    create(2, 32'd0, ok);
    wait_lpc(10, seen, waited);
    create(1, 32'd5, ok);
    sif.inst_exec = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (sif.prontos !== 4'b0000 || sif.so_ativo !== 1'b1) begin failures++; $display("FAIL midrst_state prontos=%b so=%b want 0000 1", sif.prontos, sif.so_ativo); end
    checks++; if ({sif.lpc, sif.preempt, sif.cria_ok} !== 3'b000 || sif.prog_atual !== 2'd0) begin failures++; $display("FAIL midrst_outputs pulses=%b id=%0d want 000 0", {sif.lpc, sif.preempt, sif.cria_ok}, sif.prog_atual); end
    reset = 1'b1;
    idle_inputs();
  endtask

  task automatic test_random();
    logic ok; bit seen; int waited; int p; int id; int cnt; int end_at;
    bit acc; bit exp_pre; bit ended; bit by_end; bit any_lpc;
    logic [ADDR_W-1:0] pc;
    do_reset();
    id = $urandom_range(0, NPROC - 1);
    pc = ADDR_W'($urandom_range(0, 500));
    create(id, pc, ok);
    m_valid[id] = 1'b1; m_saved[id] = pc;
    for (int r = 0; r < 40; r++) begin
      p = model_pick();
      wait_lpc(12, seen, waited);
      checks++; if (!seen || sif.prog_atual !== IDW'(p) || sif.pc_carga !== m_saved[p] + base_of(p)) begin
        failures++; $display("FAIL rand_dispatch r=%0d seen=%0d id=%0d pc=%0h want id=%0d pc=%0h", r, seen, sif.prog_atual, sif.pc_carga, p, m_saved[p] + base_of(p));
      end
      m_cur  = p;
      end_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, QUANTUM) : 0;
      cnt = 0; ended = 1'b0; by_end = 1'b0;
      while (!ended) begin
        sif.inst_exec = ($urandom_range(0, 2) != 0);
        sif.prog_end  = (end_at != 0 && cnt == end_at - 1);
        acc = 1'b0;
        sif.cria_valid = 1'b0;
        if ($urandom_range(0, 4) == 0) begin
          id = $urandom_range(0, NPROC - 1);
          pc = ADDR_W'($urandom);
          sif.cria_valid = 1'b1; sif.cria_id = IDW'(id); sif.cria_pc = pc;
          acc = !m_valid[id];
        end
        tick();
        checks++; if (sif.cria_ok !== acc) begin failures++; $display("FAIL rand_cria_ok r=%0d got=%b want=%b", r, sif.cria_ok, acc); end
        if (acc) begin m_valid[id] = 1'b1; m_saved[id] = pc; end
        exp_pre = (sif.prog_end === 1'b1) || (sif.inst_exec === 1'b1 && cnt + 1 == QUANTUM);
        checks++; if (sif.preempt !== exp_pre) begin failures++; $display("FAIL rand_preempt r=%0d cnt=%0d got=%b want=%b", r, cnt, sif.preempt, exp_pre); end
        if (sif.inst_exec === 1'b1) cnt++;
        if (sif.prog_end === 1'b1) begin
          m_valid[m_cur] = 1'b0; ended = 1'b1; by_end = 1'b1;
        end else if (cnt == QUANTUM) begin
          ended = 1'b1;
        end
      end
      idle_inputs();
      if (!by_end) begin
        pc = ADDR_W'($urandom);
        sif.pc_atual = pc;
        m_saved[m_cur] = pc - base_of(m_cur);
      end else begin
        checks++; if (sif.prontos !== model_mask()) begin failures++; $display("FAIL rand_prontos r=%0d got=%b want=%b", r, sif.prontos, model_mask()); end
        if (model_pick() < 0) begin
          any_lpc = 1'b0;
          for (int i = 0; i < 8; i++) begin
            tick();
            if (sif.lpc === 1'b1) any_lpc = 1'b1;
          end
          checks++; if (any_lpc || sif.so_ativo !== 1'b1) begin failures++; $display("FAIL rand_idle r=%0d lpc_seen=%0d so=%b want 0 1", r, any_lpc, sif.so_ativo); end
          id = $urandom_range(0, NPROC - 1);
          pc = ADDR_W'($urandom_range(0, 900));
          create(id, pc, ok);
          checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rand_idle_create r=%0d got=%b want=1", r, ok); end
          m_valid[id] = 1'b1; m_saved[id] = pc;
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    sif.pc_atual = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_end_priority();
    test_last_end();
    test_stop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/process_scheduler.md
Name: process_scheduler

Overview:
- Round-robin time-slice scheduler that sequences the program counter among up to NPROC resident user programs.
- Holds a per-program table of valid bits and saved relative PCs, and counts retired instructions against a quantum.
- On preemption or program end: pulses preempt (PC jumps to OS at 0), saves the outgoing PC, picks the next ready program and loads its absolute PC.
- Sits between the control unit (instruction-retired / end-of-program events) and the PC register (load / preempt controls).

Parameters:
- NPROC, 4, number of user program slots (ids 0..NPROC-1).
- QUANTUM, 5, retired instructions per time slice.
- OFFSET_STEP, 1000, address spacing between program images; slot i base = (i+1)*OFFSET_STEP, OS base = 0.
- ADDR_W, 32, address width.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset, sampled on rising edge of clock.
- stop  in  1  freeze: when 1, no state, counter or table changes; outputs hold, except pulses, which drop to 0.
- inst_exec  in  1  one-cycle pulse per retired user instruction.
- prog_end  in  1  current program executed its halt; slot is released.
- pc_atual  in  ADDR_W  absolute PC of running program, sampled in SAVE.
- cria_valid  in  1  request to create or launch a program.
- cria_id  in  clog2(NPROC)  slot to create.
- cria_pc  in  ADDR_W  relative start address of the new program.
- cria_ok  out  1  one-cycle pulse: creation accepted.
- preempt  out  1  one-cycle pulse: PC must jump to OS address 0.
- lpc  out  1  one-cycle pulse: PC loads pc_carga.
- pc_carga  out  ADDR_W  absolute load address, valid while lpc=1.
- prog_atual  out  clog2(NPROC)  id of the running or last-run program.
- so_ativo  out  1  1 when no user program is running (states IDLE, SAVE, SCHED).
- prontos  out  NPROC  valid mask of the program table.

Behaviour:
- Reset (reset=0 at edge): state=IDLE, all valid=0, saved PCs=0, count=0, prog_atual=0. Outputs: so_ativo=1, all pulses=0, pc_carga=0. Reset overrides stop and every other input, including in mid-slice or mid-SAVE.
- All outputs are registered; every event has one-cycle latency from the sampling edge.
- States:
  - IDLE -> SCHED when prontos != 0.
  - SCHED: round-robin search starting at (prog_atual+1) mod NPROC, wrapping, and including prog_atual last. Found -> LOAD with prog_atual=found. None -> IDLE.
  - LOAD: lpc=1 for one cycle; pc_carga = saved[prog_atual] + (prog_atual+1)*OFFSET_STEP, truncated to ADDR_W. count=0. -> RUN.
  - RUN: on each inst_exec, count+1. When the QUANTUM-th inst_exec is sampled -> SAVE, with preempt=1 in the following cycle.
  - RUN, prog_end=1: valid[prog_atual]=0, preempt=1 next cycle, -> SCHED with no save. prog_end has priority over a simultaneous quantum expiry.
  - SAVE: saved[prog_atual] = pc_atual - (prog_atual+1)*OFFSET_STEP, modulo 2^ADDR_W. -> SCHED.
- Single ready program: re-dispatched to itself after preempt (SAVE -> SCHED -> LOAD).
- Creation:
  - Accepted in any state when valid[cria_id]=0 and stop=0: sets valid, saved=cria_pc, cria_ok=1 next cycle.
  - Ignored when the slot is already valid (no cria_ok).
  - Creation in the same edge as the SCHED search is not visible to that search.
- inst_exec, prog_end and pc_atual are ignored outside RUN or SAVE, as stated above.
- cria_id >= NPROC (non-power-of-two NPROC): ignored.
- stop=1 during LOAD/SAVE: the state is held and the action is completed when stop falls. lpc/preempt are pulsed only on a non-stopped cycle.

Decomposition:
- Package sched_pkg: state enum {IDLE, SCHED, LOAD, RUN, SAVE}, ID_W = clog2(NPROC), OS_BASE = 0.
- Sub-module rr_picker (combinational): inputs are the mask and the start index; outputs are found and idx.
- Table and FSM live in process_scheduler.

Test Plan:
- Reset, then create id 0 pc 0 -> cria_ok, then lpc with pc_carga=1000 and so_ativo=0; after 5 inst_exec -> preempt pulse, then lpc again pc_carga=1000+saved (pc_atual=1005 gives 1005).
- Create ids 0 and 2, run quanta -> dispatch order 0,2,0,2; slot 2 pc_carga=3000 on first load.
- prog_end on the same edge as the 5th inst_exec of id 0 with id 1 ready -> valid[0]=0, no SAVE, next lpc for id 1 (pc_carga=2000).
- Last program ends -> preempt, then IDLE with so_ativo=1, no lpc; later create id 3 pc 7 -> lpc with pc_carga=4007.
- stop held 3 cycles in RUN with inst_exec pulses -> count unchanged; recreating a valid slot -> no cria_ok.
- reset=0 mid-slice -> next cycle prontos=0, so_ativo=1, no pulses.
